// File: rtl/mmu_page_controller.sv
// mmu_page_controller: per-process base/limit table and page-register
// sequencer for the MMU. Drives BiosSign/Page, performs context switches
// through a DRAIN/LOAD/ACK handshake and flags out-of-bounds accesses.
module mmu_page_controller #(
  parameter int NUM_PROCS = 8,
  parameter int PID_W     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PID_W-1:0]  cfg_pid,
  input  logic [15:0]       cfg_base,
  input  logic [15:0]       cfg_limit,
  input  logic              switch_req,
  input  logic [PID_W-1:0]  switch_pid,
  input  logic              bios_enter,
  input  logic              mem_access,
  input  logic [31:0]       logical_addr,
  input  logic              fault_clr,
  output logic              bios_sign,
  output logic [31:0]       page,
  output logic [PID_W-1:0]  cur_pid,
  output logic              busy,
  output logic              switch_ack,
  output logic              switch_err,
  output logic              fault
);

  typedef enum logic [2:0] {
    ST_BIOS,
    ST_IDLE,
    ST_DRAIN,
    ST_LOAD,
    ST_ACK
  } state_t;

  state_t              state;
  logic [NUM_PROCS-1:0] tbl_valid;
  logic [15:0]         tbl_base  [NUM_PROCS];
  logic [15:0]         tbl_limit [NUM_PROCS];
  logic [PID_W-1:0]    pend_pid;
  logic                violation;

  // Table payload: only the valid bits need a reset value
  always_ff @(posedge clock) begin
    if (cfg_we) begin
      tbl_base[cfg_pid]  <= cfg_base;
      tbl_limit[cfg_pid] <= cfg_limit;
    end
  end

  // Table valid bits: cleared on reset, set by any configuration write
  always_ff @(posedge clock) begin
    if (reset) begin
      tbl_valid <= '0;
    end else if (cfg_we) begin
      tbl_valid[cfg_pid] <= 1'b1;
    end
  end

  // Bounds check against the active limit; skipped in BIOS mode and while the
  // mapping is being swapped (DRAIN/LOAD)
  always_comb begin
    violation = 1'b0;
    if (mem_access && !bios_sign && (state != ST_DRAIN) && (state != ST_LOAD)) begin
      violation = (logical_addr[31:16] != 16'h0000) ||
                  (logical_addr[15:0] > page[15:0]);
    end
  end

  // Sticky fault flag: a new violation outranks a simultaneous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (violation) begin
      fault <= 1'b1;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end
  end

  // Context-switch sequencer with registered MMU-facing outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_BIOS;
      bios_sign  <= 1'b1;
      page       <= '0;
      cur_pid    <= '0;
      busy       <= 1'b0;
      switch_ack <= 1'b0;
      switch_err <= 1'b0;
      pend_pid   <= '0;
    end else begin
      switch_ack <= 1'b0;
      case (state)
        ST_BIOS: begin
          if (switch_req) begin
            pend_pid <= switch_pid;
            busy     <= 1'b1;
            state    <= ST_DRAIN;
          end
        end
        ST_IDLE: begin
          // bios_enter wins; a concurrent request stays pending and is
          // picked up from BIOS on the following cycle
          if (bios_enter) begin
            bios_sign <= 1'b1;
            page      <= '0;
            state     <= ST_BIOS;
          end else if (switch_req) begin
            pend_pid <= switch_pid;
            busy     <= 1'b1;
            state    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (tbl_valid[pend_pid]) begin
            page       <= {tbl_base[pend_pid], tbl_limit[pend_pid]};
            cur_pid    <= pend_pid;
            bios_sign  <= 1'b0;
            switch_err <= 1'b0;
          end else begin
            switch_err <= 1'b1;
          end
          switch_ack <= 1'b1;
          state      <= ST_ACK;
        end
        ST_ACK: begin
          busy  <= 1'b0;
          state <= bios_sign ? ST_BIOS : ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_BIOS;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_page_controller.sv
// Directed bench for mmu_page_controller: cycle-by-cycle vector table plus
// hand-written sequences for mid-switch reset and back-to-back switching.
module tb_mmu_page_controller;

  localparam int PID_W = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [PID_W-1:0]  cfg_pid;
  logic [15:0]       cfg_base;
  logic [15:0]       cfg_limit;
  logic              switch_req;
  logic [PID_W-1:0]  switch_pid;
  logic              bios_enter;
  logic              mem_access;
  logic [31:0]       logical_addr;
  logic              fault_clr;
  logic              bios_sign;
  logic [31:0]       page;
  logic [PID_W-1:0]  cur_pid;
  logic              busy;
  logic              switch_ack;
  logic              switch_err;
  logic              fault;

  int checks   = 0;
  int failures = 0;

  mmu_page_controller #(.NUM_PROCS(8), .PID_W(PID_W)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_pid(cfg_pid),
    .cfg_base(cfg_base), .cfg_limit(cfg_limit), .switch_req(switch_req),
    .switch_pid(switch_pid), .bios_enter(bios_enter), .mem_access(mem_access),
    .logical_addr(logical_addr), .fault_clr(fault_clr), .bios_sign(bios_sign),
    .page(page), .cur_pid(cur_pid), .busy(busy), .switch_ack(switch_ack),
    .switch_err(switch_err), .fault(fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              rst;
    logic              we;
    logic [PID_W-1:0]  cpid;
    logic [15:0]       cbase;
    logic [15:0]       climit;
    logic              req;
    logic [PID_W-1:0]  spid;
    logic              be;
    logic              ma;
    logic [31:0]       addr;
    logic              fclr;
    logic              e_bs;
    logic [31:0]       e_page;
    logic [PID_W-1:0]  e_pid;
    logic              e_busy;
    logic              e_ack;
    logic              e_err;
    logic              e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic we, input logic [PID_W-1:0] cpid,
    input logic [15:0] cbase, input logic [15:0] climit,
    input logic req, input logic [PID_W-1:0] spid, input logic be,
    input logic ma, input logic [31:0] addr, input logic fclr,
    input logic e_bs, input logic [31:0] e_page, input logic [PID_W-1:0] e_pid,
    input logic e_busy, input logic e_ack, input logic e_err, input logic e_fault);
    vec_t v;
    v.rst = rst; v.we = we; v.cpid = cpid; v.cbase = cbase; v.climit = climit;
    v.req = req; v.spid = spid; v.be = be; v.ma = ma; v.addr = addr; v.fclr = fclr;
    v.e_bs = e_bs; v.e_page = e_page; v.e_pid = e_pid; v.e_busy = e_busy;
    v.e_ack = e_ack; v.e_err = e_err; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; cfg_we = 1'b0; cfg_pid = '0; cfg_base = '0; cfg_limit = '0;
    switch_req = 1'b0; switch_pid = '0; bios_enter = 1'b0; mem_access = 1'b0;
    logical_addr = '0; fault_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag, input logic e_bs, input logic [31:0] e_page,
                             input logic [PID_W-1:0] e_pid, input logic e_busy,
                             input logic e_ack, input logic e_err, input logic e_fault);
    check({tag, "_bios_sign"},  32'(bios_sign),  32'(e_bs));
    check({tag, "_page"},       page,            e_page);
    check({tag, "_cur_pid"},    32'(cur_pid),    32'(e_pid));
    check({tag, "_busy"},       32'(busy),       32'(e_busy));
    check({tag, "_switch_ack"}, 32'(switch_ack), 32'(e_ack));
    check({tag, "_switch_err"}, 32'(switch_err), 32'(e_err));
    check({tag, "_fault"},      32'(fault),      32'(e_fault));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_idx[$];
    int cyc;
    logic seen_ack;

    //            rst we cp cbase     climit   rq sp be ma addr          fc  bs page          pid bsy ack err flt
    vecs.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0000, 0, 0, 0, 0, 0)); // 0 reset
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 32'hFFFF_0000, 0, 1, 32'h0000_0000, 0, 0, 0, 0, 0)); // 1 BIOS access, no check
    vecs.push_back(mk(0, 1, 2, 16'h0100, 16'h00FF, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0000, 0, 0, 0, 0, 0)); // 2 program pid2
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 2, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0000, 0, 1, 0, 0, 0)); // 3 req pid2 -> DRAIN
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0000, 0, 1, 0, 0, 0)); // 4 LOAD
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0100_00FF, 2, 1, 1, 0, 0)); // 5 ACK
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0100_00FF, 2, 0, 0, 0, 0)); // 6 IDLE
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 5, 0, 0, 32'h0000_0000, 0, 0, 32'h0100_00FF, 2, 1, 0, 0, 0)); // 7 req pid5
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0100_00FF, 2, 1, 0, 0, 0)); // 8 LOAD
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0100_00FF, 2, 1, 1, 1, 0)); // 9 ACK err
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0100_00FF, 2, 0, 0, 1, 0)); // 10 IDLE, err held
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 32'h0000_00FF, 0, 0, 32'h0100_00FF, 2, 0, 0, 1, 0)); // 11 at limit
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 32'h0000_0100, 0, 0, 32'h0100_00FF, 2, 0, 0, 1, 1)); // 12 limit+1
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0100_00FF, 2, 0, 0, 1, 1)); // 13 sticky
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 32'h0100_00FF, 2, 0, 0, 1, 0)); // 14 clear
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 32'h0000_0100, 1, 0, 32'h0100_00FF, 2, 0, 0, 1, 1)); // 15 set beats clear
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 32'h0100_00FF, 2, 0, 0, 1, 0)); // 16 clear
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 32'h0001_0000, 0, 0, 32'h0100_00FF, 2, 0, 0, 1, 1)); // 17 upper half set
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 32'h0100_00FF, 2, 0, 0, 1, 0)); // 18 clear
    vecs.push_back(mk(0, 1, 1, 16'h0200, 16'h0FFF, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0100_00FF, 2, 0, 0, 1, 0)); // 19 program pid1
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 1, 0, 32'h0000_0000, 0, 1, 32'h0000_0000, 2, 0, 0, 1, 0)); // 20 bios_enter wins
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0000, 2, 1, 0, 1, 0)); // 21 pending req -> DRAIN
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 1, 32'h0000_0000, 2, 1, 0, 1, 0)); // 22 LOAD
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0200_0FFF, 1, 1, 1, 0, 0)); // 23 ACK pid1
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0200_0FFF, 1, 0, 0, 0, 0)); // 24 IDLE
    vecs.push_back(mk(0, 1, 1, 16'h0300, 16'h0010, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0200_0FFF, 1, 0, 0, 0, 0)); // 25 rewrite active entry
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 0, 32'h0000_0000, 0, 0, 32'h0200_0FFF, 1, 1, 0, 0, 0)); // 26 req pid1
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1, 32'h0000_1000, 0, 0, 32'h0200_0FFF, 1, 1, 0, 0, 0)); // 27 DRAIN: no bios, no check
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 0, 0, 32'h0300_0010, 1, 1, 1, 0, 0)); // 28 ACK new entry
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 32'h0000_0011, 0, 0, 32'h0300_0010, 1, 0, 0, 0, 1)); // 29 ACK-cycle check
    vecs.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 32'h0300_0010, 1, 0, 0, 0, 0)); // 30 clear

    idle_inputs();
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; cfg_we = vecs[i].we; cfg_pid = vecs[i].cpid;
      cfg_base = vecs[i].cbase; cfg_limit = vecs[i].climit;
      switch_req = vecs[i].req; switch_pid = vecs[i].spid;
      bios_enter = vecs[i].be; mem_access = vecs[i].ma;
      logical_addr = vecs[i].addr; fault_clr = vecs[i].fclr;
      step();
      check_state($sformatf("row%0d", i), vecs[i].e_bs, vecs[i].e_page, vecs[i].e_pid,
                  vecs[i].e_busy, vecs[i].e_ack, vecs[i].e_err, vecs[i].e_fault);
    end

    // Reset while in LOAD: abort without ack, table invalidated
    idle_inputs();
    switch_req = 1'b1; switch_pid = 3'd2;
    step();
    check("midrst_drain_busy", 32'(busy), 32'd1);
    switch_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    check_state("midrst", 1'b1, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    seen_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (switch_ack) seen_ack = 1'b1;
    end
    check("midrst_no_ack", 32'(seen_ack), 32'd0);

    switch_req = 1'b1; switch_pid = 3'd2;
    step();
    switch_req = 1'b0;
    cyc = 1;
    while (!switch_ack && cyc < 10) begin
      step();
      cyc++;
    end
    check("midrst_ack_latency", 32'(cyc), 32'd3);
    check_state("midrst_retry", 1'b1, 32'h0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    mem_access = 1'b1; logical_addr = 32'hFFFF_0000;
    step();
    mem_access = 1'b0;
    check_state("midrst_stay_bios", 1'b1, 32'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Held request: back-to-back switches every 4 cycles
    reset = 1'b1;
    step();
    reset = 1'b0;
    cfg_we = 1'b1; cfg_pid = 3'd3; cfg_base = 16'h0400; cfg_limit = 16'h0040;
    step();
    cfg_we = 1'b0;
    switch_req = 1'b1; switch_pid = 3'd3;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (switch_ack) ack_idx.push_back(i);
    end
    switch_req = 1'b0;
    check("b2b_ack_count", 32'(ack_idx.size()), 32'd3);
    if (ack_idx.size() >= 2) begin
      check("b2b_first_ack", 32'(ack_idx[0]), 32'd3);
      check("b2b_ack_period", 32'(ack_idx[1] - ack_idx[0]), 32'd4);
    end else begin
      failures++;
      checks++;
      $display("FAIL b2b_acks: got %0d acks required at least 2", ack_idx.size());
    end
    step();
    check_state("b2b_final", 1'b0, 32'h0400_0040, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
